// File: rtl/usbfs_out_txn_ctrl_if.sv
// Bundles the controller's receiver, transmitter and payload-stream signals.
// slave is the controller side; master is the side that surrounds it
// (packet receiver, handshake transmitter and payload sink).
interface usbfs_out_txn_ctrl_if #(
    parameter int MAX_PKT = 8
);
    localparam int IDX_W = $clog2(MAX_PKT);

    logic [6:0]       i_devAddr;
    logic             i_eop;
    logic [3:0]       i_pid;
    logic [6:0]       i_addr;
    logic [3:0]       i_endp;
    logic             i_pidOkay;
    logic             i_tokenOkay;
    logic             i_dataOkay;
    logic [IDX_W:0]   i_rdNBytes;
    logic             o_rdEn;
    logic [IDX_W-1:0] o_rdIdx;
    logic [7:0]       i_rdByte;
    logic             o_hsReq;
    logic [3:0]       o_hsPid;
    logic             o_valid;
    logic             i_ready;
    logic [7:0]       o_data;
    logic             o_last;
    logic             o_zlp;
    logic [3:0]       o_endp;
    logic             o_setup;

    modport master (
        output i_devAddr, i_eop, i_pid, i_addr, i_endp,
               i_pidOkay, i_tokenOkay, i_dataOkay, i_rdNBytes, i_rdByte, i_ready,
        input  o_rdEn, o_rdIdx, o_hsReq, o_hsPid, o_valid, o_data,
               o_last, o_zlp, o_endp, o_setup
    );

    modport slave (
        input  i_devAddr, i_eop, i_pid, i_addr, i_endp,
               i_pidOkay, i_tokenOkay, i_dataOkay, i_rdNBytes, i_rdByte, i_ready,
        output o_rdEn, o_rdIdx, o_hsReq, o_hsPid, o_valid, o_data,
               o_last, o_zlp, o_endp, o_setup
    );
endinterface

// File: rtl/usbfs_out_txn_ctrl.sv
// USB full-speed OUT/SETUP transaction controller.
// Matches tokens, judges the following data packet, answers ACK/NAK, copies
// an accepted payload out of the receiver buffer and streams it downstream.
//
//   state | meaning
//   IDLE  | no payload held; good data with matching toggle is accepted
//   COPY  | reading the receiver buffer into the local store
//   HOLD  | presenting the stored payload on the valid/ready stream
module usbfs_out_txn_ctrl #(
    parameter int MAX_PKT  = 8,
    parameter int N_ENDP   = 2,
    parameter int TURN_CYC = 72
) (
    input  logic                 i_clk_48MHz,
    input  logic                 i_rst,
    usbfs_out_txn_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(MAX_PKT);
    localparam int NB_W  = IDX_W + 1;
    localparam int EP_W  = (N_ENDP > 1) ? $clog2(N_ENDP) : 1;
    localparam int TC_W  = $clog2(TURN_CYC + 1);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COPY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state;
    logic             tok_valid;
    logic [TC_W-1:0]  turn_cnt;
    logic [3:0]       tok_endp;
    logic             tok_setup;
    logic [N_ENDP-1:0] toggle;
    logic [NB_W-1:0]  n_bytes;
    logic [3:0]       pkt_endp;
    logic             pkt_setup;
    logic             pkt_zlp;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             cap_en;
    logic [IDX_W-1:0] cap_idx;
    logic [7:0]       store [MAX_PKT];
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             hs_req;
    logic [3:0]       hs_pid;

    logic tok_match, data_good, exp_tog, accept, xfer, out_last;

    // Token/data classification of the packet ending this cycle.
    always_comb begin
        tok_match = bus.i_eop && (bus.i_pid == PID_OUT || bus.i_pid == PID_SETUP)
                    && bus.i_pidOkay && bus.i_tokenOkay
                    && (bus.i_addr == bus.i_devAddr)
                    && ({1'b0, bus.i_endp} < 5'(N_ENDP));
        data_good = bus.i_eop && tok_valid
                    && (bus.i_pid == PID_DATA0 || bus.i_pid == PID_DATA1)
                    && bus.i_pidOkay && bus.i_dataOkay
                    && (bus.i_rdNBytes <= NB_W'(MAX_PKT));
        // SETUP always restarts the data toggle at DATA0.
        exp_tog   = tok_setup ? 1'b0 : toggle[tok_endp[EP_W-1:0]];
        accept    = data_good && (state == ST_IDLE) && (bus.i_pid[3] == exp_tog);
        xfer      = out_valid && bus.i_ready;
        out_last  = pkt_zlp || ({1'b0, out_idx} == n_bytes - NB_W'(1));
    end

    // Token window: opened by a matching token, closed by any later EOP or the turnaround timeout.
    always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
        if (i_rst) begin
            tok_valid <= 1'b0;
            turn_cnt  <= '0;
            tok_endp  <= '0;
            tok_setup <= 1'b0;
        end else if (bus.i_eop) begin
            tok_valid <= tok_match;
            if (tok_match) begin
                turn_cnt  <= TC_W'(TURN_CYC - 1);
                tok_endp  <= bus.i_endp;
                tok_setup <= (bus.i_pid == PID_SETUP);
            end
        end else if (tok_valid) begin
            if (turn_cnt == '0) tok_valid <= 1'b0;
            else                turn_cnt  <= turn_cnt - TC_W'(1);
        end
    end

    // Handshake request one cycle after a good data EOP; NAK while a payload is still held.
    always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
        if (i_rst) begin
            hs_req <= 1'b0;
            hs_pid <= 4'h0;
        end else begin
            hs_req <= data_good;
            if (data_good) hs_pid <= (state == ST_IDLE) ? PID_ACK : PID_NAK;
        end
    end

    // Per-endpoint data toggle, advanced only when a payload is actually accepted.
    always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
        if (i_rst)       toggle <= '0;
        else if (accept) toggle[tok_endp[EP_W-1:0]] <= ~exp_tog;
    end

    // Transaction FSM: accept, copy out of the receiver buffer, stream downstream.
    always_ff @(posedge i_clk_48MHz or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            n_bytes   <= '0;
            pkt_endp  <= '0;
            pkt_setup <= 1'b0;
            pkt_zlp   <= 1'b0;
            rd_en     <= 1'b0;
            rd_idx    <= '0;
            cap_en    <= 1'b0;
            cap_idx   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        n_bytes   <= bus.i_rdNBytes;
                        pkt_endp  <= tok_endp;
                        pkt_setup <= tok_setup;
                        out_idx   <= '0;
                        if (bus.i_rdNBytes == '0) begin
                            pkt_zlp   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            pkt_zlp <= 1'b0;
                            rd_en   <= 1'b1;
                            rd_idx  <= '0;
                            state   <= ST_COPY;
                        end
                    end
                end
                ST_COPY: begin
                    // The receiver answers one cycle after each read, so captures trail reads by one.
                    cap_en  <= rd_en;
                    cap_idx <= rd_idx;
                    if (rd_en) begin
                        if ({1'b0, rd_idx} == n_bytes - NB_W'(1)) rd_en  <= 1'b0;
                        else                                     rd_idx <= rd_idx + IDX_W'(1);
                    end
                    if (cap_en && ({1'b0, cap_idx} == n_bytes - NB_W'(1))) begin
                        rd_idx    <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (xfer) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            out_idx <= out_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Payload store; written only while copying, so a held payload is never disturbed.
    always_ff @(posedge i_clk_48MHz) begin
        if (state == ST_COPY && cap_en) store[cap_idx] <= bus.i_rdByte;
    end

    assign bus.o_rdEn  = rd_en;
    assign bus.o_rdIdx = rd_idx;
    assign bus.o_hsReq = hs_req;
    assign bus.o_hsPid = hs_pid;
    assign bus.o_valid = out_valid;
    assign bus.o_data  = (out_valid && !pkt_zlp) ? store[out_idx] : 8'h00;
    assign bus.o_last  = out_valid && out_last;
    assign bus.o_zlp   = out_valid && pkt_zlp;
    assign bus.o_endp  = pkt_endp;
    assign bus.o_setup = pkt_setup;
endmodule

// File: doc/usbfs_out_txn_ctrl.md
USBFS_OUT_TXN_CTRL -- requirements
Module: usbfs_out_txn_ctrl

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8, payload buffer bytes in {8,16,32,64}.
REQ-002 SHALL have parameter N_ENDP, default 2, number of OUT endpoints with toggle state (1..16).
REQ-003 SHALL have parameter TURN_CYC, default 72, 48MHz cycles allowed from token EOP to data EOP.
REQ-004 SHALL have i_clk_48MHz  input  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have i_rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have i_devAddr  input  7  device address to match.
REQ-007 SHALL have i_eop  input  1  single-cycle end-of-packet pulse from packet receiver.
REQ-008 SHALL have i_pid  input  4  PID of last packet; stable when i_eop high.
REQ-009 SHALL have i_addr  input  7  token ADDR; stable when i_eop high.
REQ-010 SHALL have i_endp  input  4  token ENDP; stable when i_eop high.
REQ-011 SHALL have i_pidOkay, i_tokenOkay, i_dataOkay  input  1 each  PID check, CRC5, CRC16 results.
REQ-012 SHALL have i_rdNBytes  input  $clog2(MAX_PKT)+1  payload byte count of last data packet.
REQ-013 SHALL have o_rdEn  output  1  receiver buffer read enable.
REQ-014 SHALL have o_rdIdx  output  $clog2(MAX_PKT)  receiver buffer read index.
REQ-015 SHALL have i_rdByte  input  8  receiver buffer byte, valid cycle after o_rdEn.
REQ-016 SHALL have o_hsReq  output  1  single-cycle handshake request to transmitter.
REQ-017 SHALL have o_hsPid  output  4  handshake PID, ACK=0010 or NAK=1010, valid with o_hsReq.
REQ-018 SHALL have o_valid / i_ready  output/input  1  payload stream handshake.
REQ-019 SHALL have o_data  output  8  payload byte; o_last  output  1  final byte of packet.
REQ-020 SHALL have o_zlp  output  1  zero-length packet marker (o_valid, o_last high, o_data 0).
REQ-021 SHALL have o_endp  output  4  and o_setup  output  1  endpoint and SETUP flag, stable while o_valid.

Function
REQ-022 Token match: i_eop, i_pid in {OUT=0001, SETUP=1101}, i_pidOkay, i_tokenOkay, i_addr==i_devAddr, i_endp<N_ENDP -> tokValid set, endp/setup latched; evaluated in every state.
REQ-023 tokValid SHALL clear on any next i_eop, or when TURN_CYC cycles elapse since token EOP without one.
REQ-024 Data eval on i_eop with tokValid, i_pid in {DATA0=0011, DATA1=1011}; pidOkay=0, dataOkay=0 or i_rdNBytes>MAX_PKT -> no handshake, no state change.
REQ-025 SETUP token forces expected toggle DATA0 for its data; OUT uses toggle[endp] (0=DATA0).
REQ-026 Good data, state IDLE, toggle matches -> o_hsReq/ACK cycle after i_eop, toggle[endp] inverted (SETUP: set to 1), go COPY (or HOLD with ZLP if i_rdNBytes==0).
REQ-027 Good data, toggle mismatch -> ACK cycle after i_eop, toggle unchanged, data discarded, state unchanged.
REQ-028 Good data while COPY or HOLD -> NAK cycle after i_eop, toggle unchanged, held payload unaffected.
REQ-029 COPY: o_rdEn high with o_rdIdx 0..n-1 on n consecutive cycles; i_rdByte captured into internal MAX_PKT x 8 store next cycle; -> HOLD after last capture (n+1 cycles).
REQ-030 HOLD: o_valid=1, o_data=store[idx]; transfer on o_valid&&i_ready advances idx; o_last when idx==n-1; transfer of o_last -> IDLE with o_valid low next cycle.
REQ-031 o_valid SHALL never drop without a transfer; o_data/o_last/o_endp/o_setup stable while o_valid && !i_ready.
REQ-032 Non-matching tokens, IN/SOF/handshake PIDs and data without tokValid SHALL produce no handshake.

Reset
REQ-033 i_rst SHALL asynchronously force IDLE, tokValid=0, all toggles 0, o_rdEn=o_hsReq=o_valid=o_last=o_zlp=o_setup=0, o_endp=0, o_rdIdx=0, o_hsPid=0; reset mid-COPY/HOLD discards payload.

Verification
REQ-034 devAddr=5: OUT addr5 endp1, DATA0 3 bytes 11 22 33 good -> ACK at eop+1, rdIdx 0,1,2, stream 11,22,33 with o_last on 33, toggle[1]=1.
REQ-035 Repeat DATA0 on endp1 after REQ-034 -> ACK, no stream, toggle[1] stays 1.
REQ-036 SETUP addr5 endp0, DATA0 8 bytes, i_ready held low, then OUT endp0 DATA1 -> ACK then NAK; stream of 8 bytes with o_setup=1 intact once i_ready rises.
REQ-037 OUT addr5, DATA1 with i_dataOkay=0; and OUT addr6 good DATA0 -> no o_hsReq in either case.
REQ-038 OUT addr5 endp0, no data for 72 cycles, then good DATA0 -> no handshake; OUT then DATA0 i_rdNBytes=0 -> ACK, single o_valid with o_zlp=o_last=1.
REQ-039 Assert i_rst during HOLD -> o_valid low immediately, all toggles 0.
